// File: rtl/fc_stream_engine.sv
// fc_stream_engine: streaming fully-connected layer, one multiply-accumulate per cycle.
// Computes out[j] = sat(round(sum_i x[i]*w[j][i]) + b[j]) in signed fixed point Q(DATA_W-FRAC_W).FRAC_W.
// Optional build macro FC_RELU_EN: when defined, negative saturated results are clamped to zero.

module fc_stream_engine #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int N_IN   = 5,
   parameter int N_OUT  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] w_data,
   input  logic              w_valid,
   output logic              w_ready,
   input  logic [DATA_W-1:0] b_data,
   input  logic              b_valid,
   output logic              b_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   // Accumulator is wide enough that N_IN full-scale products plus a bias never overflow.
   localparam int ACC_W     = 2*DATA_W + $clog2(N_IN) + 1;
   localparam int IN_IDX_W  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int OUT_IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   localparam logic [IN_IDX_W-1:0]  IN_LAST  = IN_IDX_W'(N_IN - 1);
   localparam logic [OUT_IDX_W-1:0] OUT_LAST = OUT_IDX_W'(N_OUT - 1);

   // Half-LSB rounding constant; the shift pair makes it zero when FRAC_W is 0.
   localparam logic [ACC_W:0] RND_U = ({{ACC_W{1'b0}}, 1'b1} << FRAC_W) >> 1;

   localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_MAC  = 3'd2;
   localparam logic [2:0] S_BIAS = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   logic [2:0]                state_q,   state_d;
   logic [IN_IDX_W-1:0]       in_idx_q,  in_idx_d;
   logic [OUT_IDX_W-1:0]      out_idx_q, out_idx_d;
   logic signed [ACC_W-1:0]   acc_q,     acc_d;
   logic [DATA_W-1:0]         result_q,  result_d;
   logic signed [DATA_W-1:0]  x_q [N_IN];
   logic signed [DATA_W-1:0]  x_d [N_IN];

   logic signed [DATA_W-1:0]   x_cur;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    bias_ext;
   logic signed [ACC_W-1:0]    acc_biased;
   logic signed [ACC_W:0]      rnd_sum;
   logic signed [ACC_W:0]      shifted;
   logic [DATA_W-1:0]          sat_val;
   logic [DATA_W-1:0]          final_val;

   logic in_beat;
   logic w_beat;
   logic b_beat;
   logic out_beat;

   // Handshake readiness depends only on the current state, never on the incoming valid.
   assign in_ready  = (state_q == S_LOAD);
   assign w_ready   = (state_q == S_MAC);
   assign b_ready   = (state_q == S_BIAS);
   assign out_valid = (state_q == S_OUT);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign out_data  = result_q;

   assign in_beat  = in_valid && in_ready;
   assign w_beat   = w_valid  && w_ready;
   assign b_beat   = b_valid  && b_ready;
   assign out_beat = out_valid && out_ready;

   // Datapath: product of the buffered input with the current weight, and the bias aligned to the product scale.
   assign x_cur      = x_q[in_idx_q];
   assign prod       = x_cur * $signed(w_data);
   assign prod_ext   = $signed({{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod});
   assign bias_ext   = $signed({{(ACC_W - DATA_W){b_data[DATA_W-1]}}, b_data}) <<< FRAC_W;
   assign acc_biased = acc_q + bias_ext;
   assign rnd_sum    = $signed({acc_biased[ACC_W-1], acc_biased}) + $signed(RND_U);
   assign shifted    = rnd_sum >>> FRAC_W;

   // Saturate the rounded result to the output range, then optionally apply ReLU.
   always_comb begin
      sat_val = shifted[DATA_W-1:0];
      if (shifted > SAT_MAX) begin
         sat_val = SAT_MAX[DATA_W-1:0];
      end else if (shifted < SAT_MIN) begin
         sat_val = SAT_MIN[DATA_W-1:0];
      end
`ifdef FC_RELU_EN
      final_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
      final_val = sat_val;
`endif
   end

   // Input buffer write: capture each input beat at its index; contents are reused for every output row.
   always_comb begin
      x_d = x_q;
      if (in_beat) begin
         x_d[in_idx_q] = $signed(in_data);
      end
   end

   // Control FSM: sequences load, per-row MAC, bias, and output handshake; any stall simply holds state.
   always_comb begin
      state_d   = state_q;
      in_idx_d  = in_idx_q;
      out_idx_d = out_idx_q;
      acc_d     = acc_q;
      result_d  = result_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               in_idx_d  = '0;
               out_idx_d = '0;
               acc_d     = '0;
               state_d   = S_LOAD;
            end
         end
         S_LOAD: begin
            if (in_beat) begin
               if (in_idx_q == IN_LAST) begin
                  in_idx_d = '0;
                  state_d  = S_MAC;
               end else begin
                  in_idx_d = in_idx_q + 1'b1;
               end
            end
         end
         S_MAC: begin
            if (w_beat) begin
               acc_d = acc_q + prod_ext;
               if (in_idx_q == IN_LAST) begin
                  in_idx_d = '0;
                  state_d  = S_BIAS;
               end else begin
                  in_idx_d = in_idx_q + 1'b1;
               end
            end
         end
         S_BIAS: begin
            if (b_beat) begin
               acc_d    = acc_biased;
               result_d = final_val;
               state_d  = S_OUT;
            end
         end
         S_OUT: begin
            if (out_beat) begin
               acc_d    = '0;
               in_idx_d = '0;
               if (out_idx_q == OUT_LAST) begin
                  state_d = S_DONE;
               end else begin
                  out_idx_d = out_idx_q + 1'b1;
                  state_d   = S_MAC;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and result registers with synchronous reset; reset aborts any pass in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         in_idx_q  <= '0;
         out_idx_q <= '0;
         acc_q     <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         in_idx_q  <= in_idx_d;
         out_idx_q <= out_idx_d;
         acc_q     <= acc_d;
         result_q  <= result_d;
      end
   end

   // Input buffer storage; no reset needed because every pass reloads it before use.
   always_ff @(posedge clk) begin
      x_q <= x_d;
   end

endmodule

// File: tb/tb_fc_stream_engine.sv
// tb_fc_stream_engine: directed checks of fc_stream_engine at default generics (Q8.8, 5x3),
// plus a second instance at DATA_W=8, FRAC_W=4, N_IN=16, N_OUT=10 compared against a reference model.
// Honors FC_RELU_EN when the design is built with it.

module tb_fc_stream_engine;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] w_data;
   logic        w_valid;
   logic        w_ready;
   logic [15:0] b_data;
   logic        b_valid;
   logic        b_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;

   logic        g_start;
   logic [7:0]  g_in_data;
   logic        g_in_valid;
   logic        g_in_ready;
   logic [7:0]  g_w_data;
   logic        g_w_valid;
   logic        g_w_ready;
   logic [7:0]  g_b_data;
   logic        g_b_valid;
   logic        g_b_ready;
   logic [7:0]  g_out_data;
   logic        g_out_valid;
   logic        g_out_ready;
   logic        g_busy;
   logic        g_done;

   int checks;
   int errors;

   logic [15:0] xv [5];
   logic [15:0] wv [15];
   logic [15:0] bv [3];
   logic [15:0] ev [3];

   logic signed [7:0] gx [16];
   logic signed [7:0] gw [160];
   logic signed [7:0] gb [10];
   logic [7:0]        gev [10];

`ifdef FC_RELU_EN
   localparam logic [15:0] NEG_SAT   = 16'h0000;
   localparam logic [15:0] NEG_ROUND = 16'h0000;
`else
   localparam logic [15:0] NEG_SAT   = 16'h8000;
   localparam logic [15:0] NEG_ROUND = 16'hFFFF;
`endif

   fc_stream_engine #(.DATA_W(16), .FRAC_W(8), .N_IN(5), .N_OUT(3)) u_dut (
      .clk(clk), .reset(reset), .start(start),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   fc_stream_engine #(.DATA_W(8), .FRAC_W(4), .N_IN(16), .N_OUT(10)) u_dut_gen (
      .clk(clk), .reset(reset), .start(g_start),
      .in_data(g_in_data), .in_valid(g_in_valid), .in_ready(g_in_ready),
      .w_data(g_w_data), .w_valid(g_w_valid), .w_ready(g_w_ready),
      .b_data(g_b_data), .b_valid(g_b_valid), .b_ready(g_b_ready),
      .out_data(g_out_data), .out_valid(g_out_valid), .out_ready(g_out_ready),
      .busy(g_busy), .done(g_done)
   );

   // Free-running clock, 10 time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference: round half-up, saturate, optional ReLU
   function automatic longint roundSat(input longint acc, input int dw, input int fw);
      longint r;
      longint hi;
      longint lo;
      r  = (acc + ((longint'(1) << fw) >>> 1)) >>> fw;
      hi = (longint'(1) << (dw - 1)) - 1;
      lo = -(longint'(1) << (dw - 1));
      if (r > hi) r = hi;
      if (r < lo) r = lo;
`ifdef FC_RELU_EN
      if (r < 0) r = 0;
`endif
      return r;
   endfunction

   // Fill the default-instance vectors: all x equal, weights per row, biases
   task automatic loadVectors(input logic [15:0] x, input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] b0, input logic [15:0] b1,
                              input logic [15:0] b2);
      for (int i = 0; i < 5; i++) begin
         xv[i]      = x;
         wv[i]      = w0;
         wv[5 + i]  = w1;
         wv[10 + i] = w2;
      end
      bv[0] = b0;
      bv[1] = b1;
      bv[2] = b2;
   endtask

   // Run one pass on the default instance with optional bubbles, output stall, stray starts or mid-pass reset
   task automatic applyStimulus(input string name, input int bubble_pct, input bit stall_out1,
                                input bit start_glitch, input bit abort_mid, input int exp_cycles);
      int xi;
      int wi;
      int bi;
      int oi;
      int cycles;
      int stall_cnt;
      bit saw_done;
      xi = 0; wi = 0; bi = 0; oi = 0; stall_cnt = 0; saw_done = 1'b0;
      @(negedge clk);
      start  = 1'b1;
      cycles = 1;
      while (cycles < 3000) begin
         @(negedge clk);
         cycles++;
         start = 1'b0;
         if (done) begin
            saw_done  = 1'b1;
            in_valid  = 1'b0;
            w_valid   = 1'b0;
            b_valid   = 1'b0;
            out_ready = 1'b1;
            if (start_glitch) start = 1'b1;
            break;
         end
         if (exp_cycles > 0 && cycles == 2) checkOutput({name, "_in_ready_lat"}, in_ready, 1);
         if (abort_mid && oi == 1 && wi == 7 && w_ready) begin
            reset    = 1'b1;
            in_valid = 1'b0;
            w_valid  = 1'b0;
            b_valid  = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            checkOutput({name, "_rst_ready"}, {in_ready, w_ready, b_ready}, 3'b000);
            checkOutput({name, "_rst_out_valid"}, out_valid, 0);
            checkOutput({name, "_rst_busy"}, busy, 0);
            checkOutput({name, "_rst_out_data"}, out_data, 16'h0000);
            for (int k = 0; k < 40; k++) begin
               @(negedge clk);
               if (done) checkOutput({name, "_no_done"}, done, 0);
            end
            checkOutput({name, "_idle_after_abort"}, busy, 0);
            return;
         end
         if (start_glitch && (in_ready || out_valid)) start = 1'b1;
         if (xi < 5 && $urandom_range(99) >= bubble_pct) begin
            in_valid = 1'b1;
            in_data  = xv[xi];
            if (in_ready) xi++;
         end else begin
            in_valid = 1'b0;
            in_data  = 16'h0000;
         end
         if (wi < 15 && $urandom_range(99) >= bubble_pct) begin
            w_valid = 1'b1;
            w_data  = wv[wi];
            if (w_ready) wi++;
         end else begin
            w_valid = 1'b0;
            w_data  = 16'h0000;
         end
         if (bi < 3) begin
            b_valid = 1'b1;
            b_data  = bv[bi];
            if (b_ready) bi++;
         end else begin
            b_valid = 1'b0;
            b_data  = 16'h0000;
         end
         if (stall_out1 && out_valid && oi == 1 && stall_cnt < 10) begin
            out_ready = 1'b0;
            stall_cnt++;
            checkOutput({name, "_stall_data"}, out_data, ev[1]);
            checkOutput({name, "_stall_w_ready"}, w_ready, 0);
         end else begin
            out_ready = 1'b1;
            if (out_valid) begin
               if (oi < 3) checkOutput($sformatf("%s_out%0d", name, oi), out_data, ev[oi]);
               oi++;
            end
         end
      end
      checkOutput({name, "_done_seen"}, saw_done, 1);
      checkOutput({name, "_out_count"}, oi, 3);
      if (exp_cycles > 0) checkOutput({name, "_cycles"}, cycles, exp_cycles);
      if (stall_out1) checkOutput({name, "_stall_len"}, stall_cnt, 10);
      @(negedge clk);
      start = 1'b0;
      checkOutput({name, "_done_pulse"}, done, 0);
      checkOutput({name, "_idle_after"}, busy, 0);
   endtask

   // Run one no-stall pass on the 8-bit 16x10 instance with random data against the model
   task automatic runGeneric();
      int xi;
      int wi;
      int bi;
      int oi;
      int cycles;
      bit saw_done;
      longint acc;
      for (int i = 0; i < 16; i++) gx[i] = 8'(int'($urandom_range(31)) - 16);
      for (int i = 0; i < 160; i++) gw[i] = 8'(int'($urandom_range(15)) - 8);
      for (int j = 0; j < 10; j++) gb[j] = 8'($urandom_range(255));
      for (int j = 0; j < 10; j++) begin
         acc = 0;
         for (int i = 0; i < 16; i++) acc += longint'(gx[i]) * longint'(gw[j*16 + i]);
         acc += longint'(gb[j]) * 16;
         gev[j] = 8'(roundSat(acc, 8, 4));
      end
      xi = 0; wi = 0; bi = 0; oi = 0; saw_done = 1'b0;
      @(negedge clk);
      g_start = 1'b1;
      cycles  = 1;
      while (cycles < 3000) begin
         @(negedge clk);
         cycles++;
         g_start = 1'b0;
         if (g_done) begin
            saw_done = 1'b1;
            break;
         end
         g_in_valid = (xi < 16);
         g_in_data  = (xi < 16) ? gx[xi] : 8'h00;
         if (g_in_valid && g_in_ready) xi++;
         g_w_valid = (wi < 160);
         g_w_data  = (wi < 160) ? gw[wi] : 8'h00;
         if (g_w_valid && g_w_ready) wi++;
         g_b_valid = (bi < 10);
         g_b_data  = (bi < 10) ? gb[bi] : 8'h00;
         if (g_b_valid && g_b_ready) bi++;
         g_out_ready = 1'b1;
         if (g_out_valid) begin
            if (oi < 10) checkOutput($sformatf("gen_out%0d", oi), g_out_data, gev[oi]);
            oi++;
         end
      end
      g_in_valid = 1'b0;
      g_w_valid  = 1'b0;
      g_b_valid  = 1'b0;
      checkOutput("gen_done_seen", saw_done, 1);
      checkOutput("gen_out_count", oi, 10);
      checkOutput("gen_cycles", cycles, 2 + 16 + 10 * (16 + 2));
   endtask

   // Main sequence
   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1; start = 1'b0;
      in_data = '0; in_valid = 1'b0; w_data = '0; w_valid = 1'b0;
      b_data = '0; b_valid = 1'b0; out_ready = 1'b0;
      g_start = 1'b0; g_in_data = '0; g_in_valid = 1'b0; g_w_data = '0; g_w_valid = 1'b0;
      g_b_data = '0; g_b_valid = 1'b0; g_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_ready", {in_ready, w_ready, b_ready}, 3'b000);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_busy_done", {busy, done}, 2'b00);
      checkOutput("reset_out_data", out_data, 16'h0000);
      reset = 1'b0;
      @(negedge clk);

      loadVectors(16'h0100, 16'h0080, 16'h0080, 16'h0080, 16'h0000, 16'h0100, 16'hFF00);
      ev[0] = 16'h0280; ev[1] = 16'h0380; ev[2] = 16'h0180;
      applyStimulus("basic", 0, 1'b0, 1'b0, 1'b0, 2 + 5 + 3 * (5 + 2));

      loadVectors(16'h7F00, 16'h7F00, 16'h8100, 16'h7F00, 16'h0000, 16'h0000, 16'h8000);
      ev[0] = 16'h7FFF; ev[1] = NEG_SAT; ev[2] = 16'h7FFF;
      applyStimulus("sat", 0, 1'b0, 1'b0, 1'b0, 0);

      loadVectors(16'h0000, 16'h1234, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 16'h0000);
      xv[0] = 16'h0001; wv[0] = 16'h0080; wv[5] = 16'h007F; wv[10] = 16'hFF7F;
      ev[0] = 16'h0001; ev[1] = 16'h0000; ev[2] = NEG_ROUND;
      applyStimulus("round", 0, 1'b0, 1'b0, 1'b0, 0);

      loadVectors(16'h0100, 16'h0080, 16'h0080, 16'h0080, 16'h0000, 16'h0100, 16'hFF00);
      ev[0] = 16'h0280; ev[1] = 16'h0380; ev[2] = 16'h0180;
      applyStimulus("stall", 0, 1'b1, 1'b0, 1'b0, 0);
      applyStimulus("bubble", 35, 1'b0, 1'b1, 1'b0, 0);
      applyStimulus("abort", 0, 1'b0, 1'b0, 1'b1, 0);
      applyStimulus("after_abort", 0, 1'b0, 1'b0, 1'b0, 2 + 5 + 3 * (5 + 2));

      runGeneric();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
